// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - backing data RAM with fixed latency, word writes and 4-word line fills
// Optional feature macro: DATA_RAM_ADDR_CHECK_EN (adds oerr, blocks out-of-range accesses)
module data_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ireq_valid,
  input  logic         ireq_write,
  input  logic [31:0]  iaddr,
  input  logic [31:0]  iwdata,
  output logic         oreq_ready,
  output logic         orsp_valid,
  output logic [127:0] orsp_rdata
`ifdef DATA_RAM_ADDR_CHECK_EN
  ,
  output logic         oerr
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [127:0]           rdata_q, rdata_d;

  logic [31:0]            mem_q [DEPTH];

  logic                   accept;
  logic                   commit;
  logic                   in_err;
  logic                   cur_write;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [31:0]            cur_wdata;
  logic                   cur_err;
  logic [ADDR_WIDTH-1:0]  line_base;
  logic                   unused_addr_bits;

  // Out-of-range detection only exists when the address check is built in;
  // otherwise the upper address bits are simply dropped and addresses alias.
`ifdef DATA_RAM_ADDR_CHECK_EN
  assign in_err           = |iaddr[31:ADDR_WIDTH+2];
  assign unused_addr_bits = ^iaddr[1:0];
`else
  assign in_err           = 1'b0;
  assign unused_addr_bits = ^{iaddr[31:ADDR_WIDTH+2], iaddr[1:0]};
`endif

  // Sequencing: IDLE accepts, WAIT burns the latency, RESP is the single response cycle.
  // commit marks the edge that enters RESP, where the array is written or sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ireq_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture: inputs are only meaningful on the accepting edge.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      write_d = ireq_write;
      addr_d  = iaddr[ADDR_WIDTH+1:2];
      wdata_d = iwdata;
      err_d   = in_err;
    end
  end

  // With a one-cycle latency the commit happens on the accepting edge itself,
  // so the live inputs stand in for the not-yet-captured request.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_err   = err_q;
    if (state_q == ST_IDLE) begin
      cur_write = ireq_write;
      cur_addr  = iaddr[ADDR_WIDTH+1:2];
      cur_wdata = iwdata;
      cur_err   = in_err;
    end
  end

  assign line_base = cur_addr & ~ADDR_WIDTH'(3);

  // Fill line assembly: word 0 of the line in the low lane; a blocked read returns zero.
  always_comb begin
    rdata_d = rdata_q;
    if (commit && !cur_write) begin
      if (cur_err) begin
        rdata_d = '0;
      end else begin
        rdata_d = {mem_q[line_base | ADDR_WIDTH'(3)],
                   mem_q[line_base | ADDR_WIDTH'(2)],
                   mem_q[line_base | ADDR_WIDTH'(1)],
                   mem_q[line_base]};
      end
    end
  end

  // Control and response registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array is not reset; rstn gates the write so a reset edge never commits.
  always_ff @(posedge clk) begin
    if (rstn && commit && cur_write && !cur_err) begin
      mem_q[cur_addr] <= cur_wdata;
    end
  end

  assign oreq_ready = (state_q == ST_IDLE);
  assign orsp_valid = (state_q == ST_RESP);
  assign orsp_rdata = rdata_q;

`ifdef DATA_RAM_ADDR_CHECK_EN
  assign oerr = (state_q == ST_RESP) && err_q;
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - self-checking bench for data_ram_ctrl
module tb_data_ram_ctrl;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ireq_valid = 1'b0;
  logic         ireq_write = 1'b0;
  logic [31:0]  iaddr = '0;
  logic [31:0]  iwdata = '0;
  logic         oreq_ready;
  logic         orsp_valid;
  logic [127:0] orsp_rdata;
  logic         oerr;

  data_ram_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ireq_valid (ireq_valid),
    .ireq_write (ireq_write),
    .iaddr      (iaddr),
    .iwdata     (iwdata),
    .oreq_ready (oreq_ready),
    .orsp_valid (orsp_valid),
    .orsp_rdata (orsp_rdata)
`ifdef DATA_RAM_ADDR_CHECK_EN
    ,
    .oerr       (oerr)
`endif
  );

`ifndef DATA_RAM_ADDR_CHECK_EN
  assign oerr = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a request accepted at edge e commits at edge e+LAT-1,
  // the response is visible in the cycle after that edge, and the controller
  // is busy from the accepting edge until the response cycle has passed.
  logic [31:0]  mem_m [0:1023];
  bit           mem_v [0:1023];
  int           edge_n = 0;
  int           commit_at = 0;
  int           rsp_at = -100;
  bit           pending = 1'b0;
  bit           m_rdy;
  logic         lat_wr = 1'b0;
  logic         lat_err = 1'b0;
  logic [31:0]  lat_a = '0;
  logic [31:0]  lat_d = '0;
  logic [127:0] m_rdata = '0;
  logic [127:0] m_mask = '1;
  bit           m_err = 1'b0;

  initial for (int i = 0; i < 1024; i++) mem_v[i] = 1'b0;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DATA_RAM_ADDR_CHECK_EN
    return |a[31:AW+2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_commit();
    logic [9:0] w;
    if (lat_wr) begin
      if (!lat_err) begin
        mem_m[lat_a[AW+1:2]] = lat_d;
        mem_v[lat_a[AW+1:2]] = 1'b1;
      end
    end else if (lat_err) begin
      m_rdata = '0;
      m_mask  = '1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        w = {lat_a[AW+1:4], 2'(k)};
        m_rdata[32*k +: 32] = mem_m[w];
        m_mask[32*k +: 32]  = mem_v[w] ? 32'hFFFF_FFFF : 32'h0;
      end
    end
    m_err   = lat_err;
    rsp_at  = edge_n;
    pending = 1'b0;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending = 1'b0;
      rsp_at  = -100;
      m_rdata = '0;
      m_mask  = '1;
      m_err   = 1'b0;
    end else begin
      m_rdy = !pending && (rsp_at != edge_n);
      edge_n++;
      if (pending && edge_n == commit_at) begin
        m_commit();
      end else if (m_rdy && ireq_valid) begin
        lat_wr    = ireq_write;
        lat_a     = iaddr;
        lat_d     = iwdata;
        lat_err   = addr_bad(iaddr);
        commit_at = edge_n + LAT - 1;
        pending   = 1'b1;
        if (LAT == 1) m_commit();
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the clock edge.
  always @(negedge clk) begin : cmp
    bit ev;
    bit er;
    ev = (rsp_at == edge_n);
    er = !pending && !ev;
    chk(oreq_ready === er, "oreq_ready", oreq_ready, er);
    chk(orsp_valid === ev, "orsp_valid", orsp_valid, ev);
    chk((orsp_rdata & m_mask) === (m_rdata & m_mask), "orsp_rdata", orsp_rdata & m_mask, m_rdata & m_mask);
    chk(oerr === (ev && m_err), "oerr", oerr, ev && m_err);
  end

  // Issue one request (called just after a rising edge) and collect its response.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [127:0] rd, output logic er);
    int k;
    int lat;
    ireq_valid = 1'b1;
    ireq_write = wr;
    iaddr      = a;
    iwdata     = d;
    k = 0;
    while (!oreq_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    ireq_valid = 1'b0;
    ireq_write = 1'($urandom);
    iaddr      = $urandom;
    iwdata     = $urandom;
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (orsp_valid) begin
        lat = i;
        rd  = orsp_rdata;
        er  = oerr;
      end
    end
    chk(lat == LAT, "response_latency", 128'(lat), 128'(LAT));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [127:0] rd;
    logic         er;
    int           pulses;
    int           pos [$];
    int           j;

    // Reset held with random inputs
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ireq_valid = 1'($urandom);
      ireq_write = 1'($urandom);
      iaddr      = $urandom;
      iwdata     = $urandom;
      @(negedge clk);
      chk(oreq_ready === 1'b1, "reset_ready", oreq_ready, 1'b1);
      chk(orsp_valid === 1'b0, "reset_valid", orsp_valid, 1'b0);
      chk(orsp_rdata === 128'h0, "reset_rdata", orsp_rdata, 128'h0);
      @(posedge clk); #1;
    end
    ireq_valid = 1'b0;
    rstn = 1'b1;

    // Write then line read covering it
    do_req(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, rd, er);
    do_req(1'b0, 32'h0000_001C, 32'h0, rd, er);
    chk(rd[63:32] === 32'hDEAD_BEEF, "read_after_write", rd[63:32], 32'hDEAD_BEEF);

    // Fill a whole line, read it back from a mid-line address
    do_req(1'b1, 32'h40, 32'h11, rd, er);
    do_req(1'b1, 32'h44, 32'h22, rd, er);
    do_req(1'b1, 32'h48, 32'h33, rd, er);
    do_req(1'b1, 32'h4C, 32'h44, rd, er);
    do_req(1'b0, 32'h48, 32'h0, rd, er);
    chk(rd === 128'h00000044_00000033_00000022_00000011, "full_line", rd,
        128'h00000044_00000033_00000022_00000011);

    // Back-to-back: valid held for 20 cycles
    pulses = 0;
    j = 0;
    for (int i = 0; i < 20; i++) begin
      ireq_valid = 1'b1;
      ireq_write = (i % 2 == 1);
      iaddr      = (i % 2 == 1) ? (32'h200 + 32'(4 * i)) : 32'h40;
      iwdata     = 32'h1000 + 32'(i);
      @(negedge clk);
      if (orsp_valid) begin pulses++; pos.push_back(j); end
      j++;
      @(posedge clk); #1;
    end
    ireq_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (orsp_valid) begin pulses++; pos.push_back(j); end
      j++;
    end
    chk(pulses == 4, "burst_pulses", 128'(pulses), 128'd4);
    for (int i = 1; i < pos.size(); i++)
      chk(pos[i] - pos[i-1] == LAT + 1, "burst_spacing", 128'(pos[i] - pos[i-1]), 128'(LAT + 1));
    @(posedge clk); #1;

    // Reset in the middle of a write abandons it
    do_req(1'b1, 32'h20, 32'hAAAA_AAAA, rd, er);
    ireq_valid = 1'b1;
    ireq_write = 1'b1;
    iaddr      = 32'h20;
    iwdata     = 32'h1234_5678;
    @(posedge clk); #1;
    ireq_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (orsp_valid) pulses++;
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (orsp_valid) pulses++;
    end
    chk(pulses == 0, "abort_no_response", 128'(pulses), 128'd0);
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, rd, er);
    chk(rd[31:0] === 32'hAAAA_AAAA, "abort_no_write", rd[31:0], 32'hAAAA_AAAA);

    // Out-of-range address
    do_req(1'b1, 32'h10, 32'h5555_AAAA, rd, er);
    do_req(1'b1, 32'h0000_1010, 32'hCAFE_F00D, rd, er);
`ifdef DATA_RAM_ADDR_CHECK_EN
    chk(er === 1'b1, "err_bad_write", er, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, rd, er);
    chk(rd[31:0] === 32'h5555_AAAA, "bad_write_blocked", rd[31:0], 32'h5555_AAAA);
    chk(er === 1'b0, "err_good_read", er, 1'b0);
    do_req(1'b0, 32'h0000_1010, 32'h0, rd, er);
    chk(rd === 128'h0, "bad_read_zero", rd, 128'h0);
    chk(er === 1'b1, "err_bad_read", er, 1'b1);
`else
    do_req(1'b0, 32'h10, 32'h0, rd, er);
    chk(rd[31:0] === 32'hCAFE_F00D, "alias_write", rd[31:0], 32'hCAFE_F00D);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
